// File: rtl/npu_pkg.sv
// npu_pkg: shared conv1 geometry defaults and scheduler state encoding
package npu_pkg;
  localparam int OUT1_H_DEF = 14;
  localparam int OUT1_W_DEF = 13;
  localparam int CHAN_DEF = 10;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT, DRAIN, DONE} sched_state_t;
endpackage

// File: rtl/conv1_requant.sv
// conv1_requant: arithmetic right shift, optional ReLU, saturate to int8
module conv1_requant (
  input  logic signed [23:0] din,
  input  logic        [4:0]  shift,
  input  logic               relu,
  output logic signed [7:0]  dout
);
  logic signed [23:0] sh, r;
  always_comb begin
    sh = din >>> shift;
    r = relu && sh < 0 ? '0 : sh;
    dout = r > 24'sd127 ? 8'sd127 : r < -24'sd128 ? -8'sd128 : r[7:0];
  end
endmodule

// File: rtl/conv1_sched.sv
// conv1_sched: sequences conv1 engine runs per channel and drains results to memory
module conv1_sched import npu_pkg::*; #(
  parameter int OUT1_H = OUT1_H_DEF,
  parameter int OUT1_W = OUT1_W_DEF,
  parameter int CHAN = CHAN_DEF,
  parameter int ADDR_W = 11,
  parameter int TIMEOUT = 4096
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic        [4:0]        cfg_shift,
  input  logic                     cfg_relu,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     eng_trigger,
  output logic        [3:0]        eng_chan,
  input  logic                     eng_valid,
  output logic        [3:0]        eng_rd_row,
  output logic        [3:0]        eng_rd_col,
  input  logic signed [23:0]       eng_rd_data,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic        [ADDR_W-1:0] wr_addr,
  output logic signed [7:0]        wr_data
);
  localparam int CW = $clog2(TIMEOUT + 1);
  sched_state_t state, state_n;
  logic [3:0] chan, row, col;
  logic [ADDR_W-1:0] addr;
  logic [4:0] shift;
  logic relu, prev_valid, err_q, rise, timeout, acc, last_col, last_el;
  logic [CW-1:0] cnt;
  logic signed [7:0] q;
  conv1_requant u_requant (.din(eng_rd_data), .shift(shift), .relu(relu), .dout(q));
  always_comb begin
    rise = eng_valid && !prev_valid;
    timeout = cnt == CW'(TIMEOUT - 1);
    acc = state == DRAIN && wr_ready;
    last_col = col == 4'(OUT1_W - 1);
    last_el = last_col && row == 4'(OUT1_H - 1);
    state_n = state;
    case (state)
      IDLE:    state_n = start ? TRIG : IDLE;
      TRIG:    state_n = WAIT;
      WAIT:    state_n = rise ? DRAIN : timeout ? IDLE : WAIT;
      DRAIN:   state_n = !(acc && last_el) ? DRAIN : chan == 4'(CHAN - 1) ? DONE : TRIG;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      chan <= '0;
      row <= '0;
      col <= '0;
      addr <= '0;
      shift <= '0;
      relu <= 1'b0;
      prev_valid <= 1'b0;
      err_q <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      prev_valid <= eng_valid;
      err_q <= state == WAIT && !rise && timeout;
      cnt <= state == WAIT ? cnt + CW'(1) : '0;
      if (state == IDLE && start) begin
        chan <= '0;
        addr <= '0;
        shift <= cfg_shift;
        relu <= cfg_relu;
      end
      // the write address simply counts accepted elements, which is row-major per channel
      if (acc) begin
        col <= last_col ? '0 : col + 4'(1);
        row <= last_el ? '0 : last_col ? row + 4'(1) : row;
        addr <= addr + ADDR_W'(1);
        if (last_el && chan != 4'(CHAN - 1)) chan <= chan + 4'(1);
      end
    end
  end
  always_comb begin
    busy = state inside {TRIG, WAIT, DRAIN};
    done = state == DONE;
    err = err_q;
    eng_trigger = state == TRIG;
    eng_chan = chan;
    eng_rd_row = row;
    eng_rd_col = col;
    wr_valid = state == DRAIN;
    wr_addr = addr;
    wr_data = wr_valid ? q : '0;
  end
endmodule

// File: tb/tb_conv1_sched.sv
// tb_conv1_sched: randomized self-checking bench with engine model and requant reference
module tb_conv1_sched;
  localparam int H = 14, W = 13, C = 10, N = H * W * C, TO = 4096;
  logic clk = 0, rst = 1, start = 0, cfg_relu = 0, eng_valid = 0, wr_ready = 1;
  logic [4:0] cfg_shift = 0;
  logic busy, done, err, eng_trigger, wr_valid;
  logic [3:0] eng_chan, eng_rd_row, eng_rd_col;
  logic signed [23:0] eng_rd_data;
  logic [10:0] wr_addr;
  logic signed [7:0] wr_data;
  int checks = 0, failures = 0;
  int dmode = 0, fixed_val = 0, ready_mode = 0, stuck = 0, lat = 0, cyc = 0, eng_ch = 0;
  int tbl[N];
  int done_cnt = 0, err_cnt = 0, stall_bad = 0, trig_cyc = 0, err_cyc = 0;
  int wa[$], wd[$], tch[$];
  bit prev_stall = 0;
  logic [10:0] p_addr;
  logic signed [7:0] p_data;

  conv1_sched dut (
    .clk(clk), .rst(rst), .start(start), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .busy(busy), .done(done), .err(err), .eng_trigger(eng_trigger), .eng_chan(eng_chan),
    .eng_valid(eng_valid), .eng_rd_row(eng_rd_row), .eng_rd_col(eng_rd_col),
    .eng_rd_data(eng_rd_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  assign eng_rd_data = 24'(dmode == 0 ? eng_ch * 1000 + int'(eng_rd_row) * W + int'(eng_rd_col) :
                           dmode == 1 ? fixed_val :
                           tbl[eng_ch * H * W + int'(eng_rd_row) * W + int'(eng_rd_col)]);

  initial forever begin
    @(negedge clk);
    if (eng_trigger) begin
      eng_valid = 0;
      eng_ch = int'(eng_chan);
      lat = $urandom_range(2, 8);
    end else if (lat > 0) begin
      lat--;
      if (lat == 0 && stuck == 0) eng_valid = 1;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    wr_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (wr_valid && wr_ready) begin
      wa.push_back(int'(wr_addr));
      wd.push_back(int'(wr_data));
    end
    if (eng_trigger) begin
      tch.push_back(int'(eng_chan));
      trig_cyc = cyc;
    end
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (prev_stall && !(wr_valid && wr_addr == p_addr && wr_data == p_data)) stall_bad++;
    prev_stall = wr_valid && !wr_ready && !rst;
    p_addr = wr_addr;
    p_data = wr_data;
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int val(int ch, int r, int c);
    return dmode == 0 ? ch * 1000 + r * W + c : dmode == 1 ? fixed_val : tbl[ch * H * W + r * W + c];
  endfunction

  // floor division by 2**s is the arithmetic shift; then ReLU and int8 clamp
  function automatic int rq(int v, int s, bit relu);
    int d;
    if (s >= 23) d = v < 0 ? -1 : 0;
    else begin
      d = v / (1 << s);
      if (v < 0 && d * (1 << s) != v) d = d - 1;
    end
    if (relu && d < 0) d = 0;
    return d > 127 ? 127 : d < -128 ? -128 : d;
  endfunction

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear();
    wa.delete();
    wd.delete();
    tch.delete();
    done_cnt = 0;
    err_cnt = 0;
    stall_bad = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    start = 0;
    step();
    step();
    rst = 0;
    step();
  endtask

  task automatic go(int s, bit r);
    start = 1;
    cfg_shift = 5'(s);
    cfg_relu = r;
    step();
    start = 0;
  endtask

  task automatic wait_end(int budget);
    for (int i = 0; i < budget && done_cnt == 0 && err_cnt == 0; i++) step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, done, err, eng_trigger, wr_valid, eng_chan, eng_rd_row, eng_rd_col, wr_addr, wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b err=%b trig=%b wv=%b chan=%0d row=%0d col=%0d addr=%0d data=%0d, expected all 0",
               busy, done, err, eng_trigger, wr_valid, eng_chan, eng_rd_row, eng_rd_col, wr_addr, wr_data);
    end
  endtask

  task automatic test_basic();
    int ed;
    do_reset();
    clear();
    dmode = 0;
    ready_mode = 0;
    go(0, 0);
    wait_end(3000);
    checks++;
    if (wa.size() != N || done_cnt != 1 || err_cnt != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_summary: writes=%0d done=%0d err=%0d busy=%b, expected %0d 1 0 0", wa.size(), done_cnt, err_cnt, busy, N);
    end
    for (int i = 0; i < wa.size() && i < N; i++) begin
      ed = rq(val(i / (H * W), (i % (H * W)) / W, i % W), 0, 0);
      checks++;
      if (wa[i] != i || wd[i] != ed) begin
        failures++;
        $display("FAIL basic_write[%0d]: addr=%0d data=%0d, expected addr=%0d data=%0d", i, wa[i], wd[i], i, ed);
      end
    end
    checks++;
    if (tch.size() != C) begin
      failures++;
      $display("FAIL basic_triggers: got %0d pulses, expected %0d", tch.size(), C);
    end
    for (int i = 0; i < tch.size() && i < C; i++) begin
      checks++;
      if (tch[i] != i) begin
        failures++;
        $display("FAIL basic_trig_chan[%0d]: got %0d expected %0d", i, tch[i], i);
      end
    end
  endtask

  task automatic test_requant();
    int cv[4] = '{-300, -300, 8388607, -1};
    int cs[4] = '{2, 2, 4, 31};
    int cr[4] = '{0, 1, 0, 0};
    int ce[4] = '{-75, 0, 127, -1};
    int v, s, ex;
    bit r;
    dmode = 1;
    ready_mode = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 4) begin
        v = cv[i];
        s = cs[i];
        r = cr[i][0];
        ex = ce[i];
      end else begin
        v = int'($urandom_range(0, 16777215)) - 8388608;
        s = $urandom_range(0, 31);
        r = 1'($urandom_range(0, 1));
        ex = rq(v, s, r);
      end
      fixed_val = v;
      do_reset();
      go(s, r);
      for (int k = 0; k < 40 && wr_valid !== 1'b1; k++) step();
      checks++;
      if (wr_valid !== 1'b1 || wr_data !== 8'(ex)) begin
        failures++;
        $display("FAIL requant[%0d] v=%0d shift=%0d relu=%0d: wr_valid=%b data=%0d, expected 1 %0d", i, v, s, r, wr_valid, wr_data, ex);
      end
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    int s, ed;
    bit r;
    for (int i = 0; i < N; i++) tbl[i] = int'($urandom_range(0, 16777215)) - 8388608;
    do_reset();
    clear();
    dmode = 2;
    ready_mode = 1;
    s = $urandom_range(0, 12);
    r = 1'($urandom_range(0, 1));
    go(s, r);
    wait_end(9000);
    ready_mode = 0;
    checks++;
    if (wa.size() != N || done_cnt != 1 || stall_bad != 0) begin
      failures++;
      $display("FAIL backpressure_summary: writes=%0d done=%0d unstable_stalls=%0d, expected %0d 1 0", wa.size(), done_cnt, stall_bad, N);
    end
    for (int i = 0; i < wa.size() && i < N; i++) begin
      ed = rq(val(i / (H * W), (i % (H * W)) / W, i % W), s, r);
      checks++;
      if (wa[i] != i || wd[i] != ed) begin
        failures++;
        $display("FAIL bp_write[%0d]: addr=%0d data=%0d, expected addr=%0d data=%0d", i, wa[i], wd[i], i, ed);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    clear();
    dmode = 0;
    stuck = 1;
    go(0, 0);
    for (int i = 0; i < TO + 200 && err_cnt == 0; i++) step();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || err_cyc - trig_cyc != TO + 1) begin
      failures++;
      $display("FAIL timeout_pulse: err=%b busy=%b delay=%0d, expected 1 0 %0d", err, busy, err_cyc - trig_cyc, TO + 1);
    end
    step();
    checks++;
    if (err !== 1'b0 || err_cnt != 1 || wa.size() != 0 || done_cnt != 0) begin
      failures++;
      $display("FAIL timeout_after: err=%b err_pulses=%0d writes=%0d done=%0d, expected 0 1 0 0", err, err_cnt, wa.size(), done_cnt);
    end
    stuck = 0;
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    do_reset();
    clear();
    dmode = 0;
    ready_mode = 0;
    go(0, 0);
    for (int i = 0; i < 1500 && !hit; i++) begin
      if (wr_valid === 1'b1 && eng_chan == 4'd3 && wr_addr == 11'(3 * H * W + 50)) hit = 1;
      else step();
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL reset_mid_reach: chan3 element 50 not reached, addr=%0d", wr_addr);
    end
    rst = 1;
    start = 1;
    step();
    checks++;
    if ({busy, done, err, eng_trigger, wr_valid, eng_chan, eng_rd_row, eng_rd_col, wr_addr, wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_mid_state: busy=%b trig=%b wv=%b chan=%0d row=%0d col=%0d addr=%0d, expected all 0",
               busy, eng_trigger, wr_valid, eng_chan, eng_rd_row, eng_rd_col, wr_addr);
    end
    rst = 0;
    start = 0;
    step();
    clear();
    go(0, 0);
    wait_end(3000);
    checks++;
    if (wa.size() != N || tch.size() != C || done_cnt != 1) begin
      failures++;
      $display("FAIL reset_mid_rerun: writes=%0d triggers=%0d done=%0d, expected %0d %0d 1", wa.size(), tch.size(), done_cnt, N, C);
    end
    checks++;
    if (tch.size() == 0 || wa.size() == 0 || tch[0] != 0 || wa[0] != 0) begin
      failures++;
      $display("FAIL reset_mid_restart: first chan=%0d first addr=%0d, expected 0 0",
               tch.size() ? tch[0] : -1, wa.size() ? wa[0] : -1);
    end
  endtask

  task automatic test_collisions();
    bit hit = 0;
    do_reset();
    clear();
    dmode = 0;
    ready_mode = 0;
    go(0, 0);
    for (int i = 0; i < 20 && tch.size() == 0; i++) step();
    step();
    start = 1;
    cfg_shift = 5;
    step();
    start = 0;
    wait_end(3000);
    checks++;
    if (done !== 1'b1 || tch.size() != C || wa.size() != N || wd[100] != rq(val(0, 7, 9), 0, 0)) begin
      failures++;
      $display("FAIL collision_wait: done=%b triggers=%0d writes=%0d data100=%0d, expected 1 %0d %0d %0d",
               done, tch.size(), wa.size(), wa.size() > 100 ? wd[100] : -1, C, N, rq(val(0, 7, 9), 0, 0));
    end
    start = 1;
    cfg_shift = 9;
    step();
    cfg_shift = 4;
    step();
    start = 0;
    checks++;
    if (eng_trigger !== 1'b1 || busy !== 1'b1 || eng_chan !== 4'd0) begin
      failures++;
      $display("FAIL collision_restart: trig=%b busy=%b chan=%0d, expected 1 1 0", eng_trigger, busy, eng_chan);
    end
    for (int i = 0; i < 300 && !hit; i++) begin
      if (wr_valid === 1'b1 && wr_addr == 11'd100) hit = 1;
      else step();
    end
    checks++;
    if (!hit || wr_data !== 8'(rq(val(0, 7, 9), 4, 0))) begin
      failures++;
      $display("FAIL collision_cfg: reached=%b data=%0d, expected 1 %0d", hit, wr_data, rq(val(0, 7, 9), 4, 0));
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_requant();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_collisions();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
